// File: rtl/par_shift_reg_if.sv
// Bus bundle for par_shift_reg: load/shift controls in, register state and status out.
// The master drives the controls and the slave (the shifter) drives q/cout/busy/done.
interface par_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH) + 1
);
    logic             load;
    logic [WIDTH-1:0] ld_data;
    logic             start;
    logic             dir;
    logic [1:0]       mode;
    logic [AW-1:0]    amount;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             cout;
    logic             busy;
    logic             done;

    modport master (
        output load, ld_data, start, dir, mode, amount, sin,
        input  q, cout, busy, done
    );

    modport slave (
        input  load, ld_data, start, dir, mode, amount, sin,
        output q, cout, busy, done
    );
endinterface

// File: rtl/par_shift_reg.sv
// Parallel-load shift register performing multi-cycle 1-bit-per-cycle shifts
// (logical, rotate, arithmetic, serial-fill) under an IDLE/SHIFT/DONE FSM.
module par_shift_reg #(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    par_shift_reg_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
    typedef enum logic [1:0] {M_LOGIC, M_ROT, M_ARITH, M_SERIAL} mode_e;

    state_e           state, state_n;
    mode_e            mode_r, mode_n;
    logic             dir_r, dir_n;
    logic [AW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] q_r, q_n;
    logic             cout_r, cout_n;

    logic             out_bit;
    logic             fill;
    logic [WIDTH-1:0] shifted;
    logic [AW-1:0]    amt_lim;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mode_r <= M_LOGIC;
            dir_r  <= 1'b0;
            cnt    <= '0;
            q_r    <= '0;
            cout_r <= 1'b0;
        end else begin
            state  <= state_n;
            mode_r <= mode_n;
            dir_r  <= dir_n;
            cnt    <= cnt_n;
            q_r    <= q_n;
            cout_r <= cout_n;
        end
    end

    always_comb begin
        state_n = state;
        mode_n  = mode_r;
        dir_n   = dir_r;
        cnt_n   = cnt;
        q_n     = q_r;
        cout_n  = cout_r;

        amt_lim = (bus.amount > AW'(WIDTH)) ? AW'(WIDTH) : bus.amount;

        // Single-step datapath driven only by the latched dir/mode.
        out_bit = dir_r ? q_r[0] : q_r[WIDTH-1];
        case (mode_r)
            M_LOGIC: fill = 1'b0;
            M_ROT:   fill = out_bit;
            M_ARITH: fill = dir_r & q_r[WIDTH-1];
            default: fill = bus.sin;
        endcase
        shifted = dir_r ? {fill, q_r[WIDTH-1:1]} : {q_r[WIDTH-2:0], fill};

        case (state)
            IDLE: begin
                if (bus.load) begin
                    q_n = bus.ld_data;
                end else if (bus.start) begin
                    dir_n   = bus.dir;
                    mode_n  = mode_e'(bus.mode);
                    cnt_n   = amt_lim;
                    state_n = (amt_lim != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                q_n    = shifted;
                cout_n = out_bit;
                cnt_n  = cnt - AW'(1);
                if (cnt == AW'(1)) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.q    = q_r;
    assign bus.cout = cout_r;
    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
endmodule

// File: tb/tb_par_shift_reg.sv
// Self-checking bench for par_shift_reg: directed cases plus random operations
// checked against a whole-operation arithmetic reference model.
module tb_par_shift_reg;
    localparam int W = 8;
    localparam int A = $clog2(W) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    par_shift_reg_if #(.WIDTH(W), .AW(A)) bus ();
    par_shift_reg #(.WIDTH(W), .AW(A)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] mq;
    logic         mc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result of an n-step operation, computed in one go from shift arithmetic.
    function automatic void model(input logic d, input logic [1:0] m, input int n,
                                  input logic [15:0] sv);
        logic [2*W-1:0]      full;
        logic [W-1:0]        r;
        logic signed [W-1:0] s;
        if (n == 0) return;
        if (!d) begin
            full = {{W{1'b0}}, mq} << n;
            r    = full[W-1:0];
            mc   = full[W];
            if (m == 2'b01) r = r | full[2*W-1:W];
            if (m == 2'b11)
                for (int i = 0; i < n; i++) if (sv[i]) r[n-1-i] = 1'b1;
        end else begin
            full = {mq, {W{1'b0}}} >> n;
            r    = full[2*W-1:W];
            mc   = full[W-1];
            if (m == 2'b01) r = r | full[W-1:0];
            if (m == 2'b10) begin
                s = mq;
                r = s >>> n;
            end
            if (m == 2'b11)
                for (int i = 0; i < n; i++) if (sv[i]) r[W-n+i] = 1'b1;
        end
        mq = r;
    endfunction

    task automatic do_load(input logic [W-1:0] v);
        @(negedge clk);
        bus.load    = 1'b1;
        bus.ld_data = v;
        @(negedge clk);
        bus.load = 1'b0;
        mq = v;
        chk("load_q", bus.q, mq);
        chk("load_cout", bus.cout, mc);
    endtask

    task automatic do_op(input logic d, input logic [1:0] m, input logic [A-1:0] amt,
                         input bit rnd_sin, input logic [15:0] pat, input bit poke);
        int n;
        int si;
        logic s;
        logic [15:0] sv;
        n  = (int'(amt) > W) ? W : int'(amt);
        si = 0;
        sv = '0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.dir    = d;
        bus.mode   = m;
        bus.amount = amt;
        for (int e = 1; e <= n + 1; e++) begin
            @(negedge clk);
            if (e == 1) begin
                bus.start  = poke;
                bus.load   = poke;
                bus.ld_data = W'($urandom);
                bus.dir    = 1'($urandom);
                bus.mode   = 2'($urandom);
                bus.amount = A'($urandom);
            end else if (e == 2) begin
                bus.start = 1'b0;
                bus.load  = 1'b0;
            end
            chk("busy", bus.busy, (e <= n));
            chk("done_latency", bus.done, (e == n + 1));
            if (e <= n) begin
                s = rnd_sin ? 1'($urandom) : pat[si];
                bus.sin = s;
                sv[si]  = s;
                si++;
            end
        end
        model(d, m, n, sv);
        chk("op_q", bus.q, mq);
        chk("op_cout", bus.cout, mc);
        bus.start = 1'b0;
        bus.load  = 1'b0;
        @(negedge clk);
        chk("idle_done", bus.done, 1'b0);
        chk("idle_busy", bus.busy, 1'b0);
        chk("idle_q", bus.q, mq);
    endtask

    initial begin
        rst = 1'b1;
        bus.load = 1'b0; bus.ld_data = '0; bus.start = 1'b0; bus.dir = 1'b0;
        bus.mode = '0; bus.amount = '0; bus.sin = 1'b0;
        mq = '0; mc = 1'b0;
        #12;
        chk("rst_q", bus.q, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        @(negedge clk);
        rst = 1'b0;

        do_load(8'hA9);
        do_op(1'b1, 2'b00, A'(1), 1'b1, '0, 1'b0);
        chk("r035_q", bus.q, 8'h54);
        chk("r035_cout", bus.cout, 1'b1);

        do_load(8'h56);
        do_op(1'b0, 2'b01, A'(3), 1'b1, '0, 1'b0);
        chk("r036_q", bus.q, 8'hB2);
        chk("r036_cout", bus.cout, 1'b0);

        do_load(8'h96);
        do_op(1'b1, 2'b10, A'(2), 1'b1, '0, 1'b0);
        chk("r037_q", bus.q, 8'hE5);
        chk("r037_cout", bus.cout, 1'b1);

        do_load(8'h00);
        do_op(1'b0, 2'b11, A'(4), 1'b0, 16'b1101, 1'b0);
        chk("r038_q", bus.q, 8'h0B);

        do_load(8'h5D);
        do_op(1'b1, 2'b01, A'(0), 1'b1, '0, 1'b1);
        chk("amt0_q", bus.q, 8'h5D);

        do_load(8'hFF);
        do_op(1'b0, 2'b00, A'(12), 1'b1, '0, 1'b0);
        chk("amt12_q", bus.q, 8'h00);

        // load and start together: load wins, no operation begins
        @(negedge clk);
        bus.load = 1'b1; bus.start = 1'b1; bus.ld_data = 8'h3C; bus.amount = A'(3);
        @(negedge clk);
        bus.load = 1'b0; bus.start = 1'b0;
        mq = 8'h3C;
        chk("ldst_q", bus.q, 8'h3C);
        chk("ldst_busy", bus.busy, 1'b0);
        @(negedge clk);
        chk("ldst_busy2", bus.busy, 1'b0);
        chk("ldst_done2", bus.done, 1'b0);

        // pulses of load/start in the middle of a shift are ignored
        do_op(1'b1, 2'b00, A'(5), 1'b1, '0, 1'b1);

        // idle hold
        repeat (3) @(negedge clk);
        chk("idle_hold_q", bus.q, mq);
        chk("idle_hold_cout", bus.cout, mc);

        // asynchronous reset in the middle of a shift
        do_load(8'hC7);
        @(negedge clk);
        bus.start = 1'b1; bus.dir = 1'b0; bus.mode = 2'b01; bus.amount = A'(6);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", bus.busy, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_q", bus.q, 0);
        chk("arst_cout", bus.cout, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        @(negedge clk);
        chk("arst_hold_done", bus.done, 0);
        rst = 1'b0;
        mq = '0; mc = 1'b0;
        do_load(8'h81);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0) do_load(W'($urandom));
            do_op(1'($urandom), 2'($urandom), A'($urandom_range(0, 15)), 1'b1, '0,
                  ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
